// File: rtl/pc_fetch_unit_if.sv
// Fetch-side bus between the redirect producers / decode stage and pc_fetch_unit.
// master = surrounding pipeline, slave = pc_fetch_unit.
interface pc_fetch_unit_if;
  logic        Stall;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic        Jump;
  logic [31:0] Jump_Target;
  logic [31:0] Program_Count;
  logic [31:0] Pc_Plus_4;
  logic        Fetch_Valid;
  logic        Pc_Out_Of_Range;
  logic        Misalign_Trap;
  logic [31:0] Trap_Pc;

  modport master (
    output Stall, Branch_Taken, Branch_Target, Jump, Jump_Target,
    input  Program_Count, Pc_Plus_4, Fetch_Valid, Pc_Out_Of_Range,
           Misalign_Trap, Trap_Pc
  );

  modport slave (
    input  Stall, Branch_Taken, Branch_Target, Jump, Jump_Target,
    output Program_Count, Pc_Plus_4, Fetch_Valid, Pc_Out_Of_Range,
           Misalign_Trap, Trap_Pc
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter / next-PC generator feeding instruction_mem (BOOT/RUN/STALL/TRAP FSM).
// Define PC_MISALIGN_TRAP_EN to trap on misaligned redirects; otherwise targets are word-aligned.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
  parameter int unsigned MEM_SIZE    = 1024
) (
  input  logic             Clk_Core,
  input  logic             Rst_Core,
  pc_fetch_unit_if.slave   bus
);

  typedef enum logic [1:0] {BOOT, RUN, STALL, TRAP} state_e;

  localparam logic [32:0] PC_LIMIT = 33'(MEM_SIZE) << 2;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        fetch_valid_q;
  logic [31:0] pc_plus_4;
  logic [31:0] target_raw;
  logic [31:0] target;
  logic        redirect;
  logic [31:0] pc_d;

  always_comb begin
    pc_plus_4  = pc_q + 32'd4;
    redirect   = bus.Jump | bus.Branch_Taken;
    // Jump outranks a simultaneously resolved branch.
    target_raw = bus.Jump ? bus.Jump_Target : bus.Branch_Target;
`ifdef PC_MISALIGN_TRAP_EN
    target     = target_raw;
`else
    target     = target_raw & ~32'h3;
`endif
    pc_d       = redirect ? target : pc_plus_4;
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic        trap_q;
  logic [31:0] trap_pc_q;
  logic        misaligned;

  assign misaligned = redirect && (target[1:0] != 2'b00);
`endif

  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      trap_q        <= 1'b0;
      trap_pc_q     <= 32'h0;
`endif
    end else begin
`ifdef PC_MISALIGN_TRAP_EN
      trap_q <= 1'b0;
`endif
      case (state_q)
        // Bubble states ignore Stall and redirects and resume sequentially.
        BOOT, TRAP: begin
          state_q       <= RUN;
          pc_q          <= pc_plus_4;
          fetch_valid_q <= 1'b1;
        end
        default: begin
          if (bus.Stall) begin
            state_q       <= STALL;
            fetch_valid_q <= 1'b1;
          end
`ifdef PC_MISALIGN_TRAP_EN
          else if (misaligned) begin
            state_q       <= TRAP;
            pc_q          <= TRAP_VECTOR;
            fetch_valid_q <= 1'b0;
            trap_q        <= 1'b1;
            trap_pc_q     <= target;
          end
`endif
          else begin
            state_q       <= RUN;
            pc_q          <= pc_d;
            fetch_valid_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.Program_Count   = pc_q;
  assign bus.Pc_Plus_4       = pc_plus_4;
  assign bus.Fetch_Valid     = fetch_valid_q;
  assign bus.Pc_Out_Of_Range = ({1'b0, pc_q} >= PC_LIMIT);
`ifdef PC_MISALIGN_TRAP_EN
  assign bus.Misalign_Trap   = trap_q;
  assign bus.Trap_Pc         = trap_pc_q;
`else
  assign bus.Misalign_Trap   = 1'b0;
  assign bus.Trap_Pc         = 32'h0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit (MEM_SIZE=4 so the range boundary is hit early).
// Expectations follow PC_MISALIGN_TRAP_EN when it is defined for the build.
module tb_pc_fetch_unit;
  logic clk;
  logic rst;
  int   cmp_cnt;
  int   fail_cnt;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .TRAP_VECTOR(32'h0000_0100),
    .MEM_SIZE   (4)
  ) dut (
    .Clk_Core(clk),
    .Rst_Core(rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.Stall = 1'b0; bus.Jump = 1'b0; bus.Branch_Taken = 1'b0;
    bus.Jump_Target = 32'h0; bus.Branch_Target = 32'h0;
    step(); step();
    rst = 1'b0;
    #1;
    cmp_cnt++; if (bus.Program_Count !== 32'h0) begin fail_cnt++; $display("FAIL reset_pc got=%h exp=%h", bus.Program_Count, 32'h0); end
    cmp_cnt++; if (bus.Fetch_Valid !== 1'b0) begin fail_cnt++; $display("FAIL reset_fv got=%b exp=0", bus.Fetch_Valid); end
    cmp_cnt++; if (bus.Misalign_Trap !== 1'b0) begin fail_cnt++; $display("FAIL reset_trap got=%b exp=0", bus.Misalign_Trap); end
    cmp_cnt++; if (bus.Trap_Pc !== 32'h0) begin fail_cnt++; $display("FAIL reset_trap_pc got=%h exp=0", bus.Trap_Pc); end
    $display("reset: pc=%h fv=%b", bus.Program_Count, bus.Fetch_Valid);
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    exp_pc = 32'h4;
    for (int i = 0; i < 4; i++) begin
      step();
      cmp_cnt++; if (bus.Program_Count !== exp_pc) begin fail_cnt++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, bus.Program_Count, exp_pc); end
      cmp_cnt++; if (bus.Fetch_Valid !== 1'b1) begin fail_cnt++; $display("FAIL seq_fv[%0d] got=%b exp=1", i, bus.Fetch_Valid); end
      cmp_cnt++; if (bus.Pc_Plus_4 !== exp_pc + 32'd4) begin fail_cnt++; $display("FAIL seq_plus4[%0d] got=%h exp=%h", i, bus.Pc_Plus_4, exp_pc + 32'd4); end
      cmp_cnt++; if (bus.Pc_Out_Of_Range !== (exp_pc >= 32'h10)) begin fail_cnt++; $display("FAIL seq_oor[%0d] got=%b exp=%b", i, bus.Pc_Out_Of_Range, exp_pc >= 32'h10); end
      $display("seq: pc=%h fv=%b oor=%b", bus.Program_Count, bus.Fetch_Valid, bus.Pc_Out_Of_Range);
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_branch();
    bus.Branch_Taken = 1'b1; bus.Branch_Target = 32'h40;
    step();
    bus.Branch_Taken = 1'b0;
    cmp_cnt++; if (bus.Program_Count !== 32'h40) begin fail_cnt++; $display("FAIL branch_pc got=%h exp=%h", bus.Program_Count, 32'h40); end
    cmp_cnt++; if (bus.Fetch_Valid !== 1'b1) begin fail_cnt++; $display("FAIL branch_fv got=%b exp=1", bus.Fetch_Valid); end
    $display("branch: pc=%h fv=%b", bus.Program_Count, bus.Fetch_Valid);
  endtask

  task automatic test_jump_priority();
    bus.Jump = 1'b1; bus.Jump_Target = 32'h80;
    bus.Branch_Taken = 1'b1; bus.Branch_Target = 32'h40;
    step();
    bus.Jump = 1'b0; bus.Branch_Taken = 1'b0;
    cmp_cnt++; if (bus.Program_Count !== 32'h80) begin fail_cnt++; $display("FAIL jump_prio_pc got=%h exp=%h", bus.Program_Count, 32'h80); end
    $display("jump_prio: pc=%h", bus.Program_Count);
  endtask

  task automatic test_stall();
    bus.Jump = 1'b1; bus.Jump_Target = 32'h20;
    step();
    cmp_cnt++; if (bus.Program_Count !== 32'h20) begin fail_cnt++; $display("FAIL stall_setup_pc got=%h exp=%h", bus.Program_Count, 32'h20); end
    bus.Stall = 1'b1; bus.Jump_Target = 32'h200;
    for (int i = 0; i < 3; i++) begin
      step();
      cmp_cnt++; if (bus.Program_Count !== 32'h20) begin fail_cnt++; $display("FAIL stall_hold_pc[%0d] got=%h exp=%h", i, bus.Program_Count, 32'h20); end
      cmp_cnt++; if (bus.Fetch_Valid !== 1'b1) begin fail_cnt++; $display("FAIL stall_fv[%0d] got=%b exp=1", i, bus.Fetch_Valid); end
      $display("stall: pc=%h fv=%b", bus.Program_Count, bus.Fetch_Valid);
    end
    bus.Stall = 1'b0;
    step();
    bus.Jump = 1'b0;
    cmp_cnt++; if (bus.Program_Count !== 32'h200) begin fail_cnt++; $display("FAIL stall_release_pc got=%h exp=%h", bus.Program_Count, 32'h200); end
    $display("stall_release: pc=%h", bus.Program_Count);
  endtask

  task automatic test_misalign();
    logic [31:0] exp_pc0, exp_pc1, exp_tpc;
    logic        exp_trap, exp_fv0;
`ifdef PC_MISALIGN_TRAP_EN
    exp_pc0 = 32'h100; exp_pc1 = 32'h104; exp_tpc = 32'h42; exp_trap = 1'b1; exp_fv0 = 1'b0;
`else
    exp_pc0 = 32'h40;  exp_pc1 = 32'h44;  exp_tpc = 32'h0;  exp_trap = 1'b0; exp_fv0 = 1'b1;
`endif
    bus.Jump = 1'b1; bus.Jump_Target = 32'h42;
    step();
    bus.Jump = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    bus.Stall = 1'b1;
`endif
    cmp_cnt++; if (bus.Program_Count !== exp_pc0) begin fail_cnt++; $display("FAIL misalign_pc got=%h exp=%h", bus.Program_Count, exp_pc0); end
    cmp_cnt++; if (bus.Misalign_Trap !== exp_trap) begin fail_cnt++; $display("FAIL misalign_trap got=%b exp=%b", bus.Misalign_Trap, exp_trap); end
    cmp_cnt++; if (bus.Trap_Pc !== exp_tpc) begin fail_cnt++; $display("FAIL misalign_trap_pc got=%h exp=%h", bus.Trap_Pc, exp_tpc); end
    cmp_cnt++; if (bus.Fetch_Valid !== exp_fv0) begin fail_cnt++; $display("FAIL misalign_fv got=%b exp=%b", bus.Fetch_Valid, exp_fv0); end
    $display("misalign: pc=%h trap=%b trap_pc=%h fv=%b", bus.Program_Count, bus.Misalign_Trap, bus.Trap_Pc, bus.Fetch_Valid);
    step();
    bus.Stall = 1'b0;
    cmp_cnt++; if (bus.Program_Count !== exp_pc1) begin fail_cnt++; $display("FAIL post_trap_pc got=%h exp=%h", bus.Program_Count, exp_pc1); end
    cmp_cnt++; if (bus.Misalign_Trap !== 1'b0) begin fail_cnt++; $display("FAIL post_trap_pulse got=%b exp=0", bus.Misalign_Trap); end
    cmp_cnt++; if (bus.Fetch_Valid !== 1'b1) begin fail_cnt++; $display("FAIL post_trap_fv got=%b exp=1", bus.Fetch_Valid); end
    cmp_cnt++; if (bus.Trap_Pc !== exp_tpc) begin fail_cnt++; $display("FAIL post_trap_hold got=%h exp=%h", bus.Trap_Pc, exp_tpc); end
    $display("post_trap: pc=%h trap=%b fv=%b", bus.Program_Count, bus.Misalign_Trap, bus.Fetch_Valid);
  endtask

  task automatic test_wrap();
    bus.Jump = 1'b1; bus.Jump_Target = 32'hFFFF_FFFC;
    step();
    bus.Jump = 1'b0;
    cmp_cnt++; if (bus.Program_Count !== 32'hFFFF_FFFC) begin fail_cnt++; $display("FAIL wrap_top_pc got=%h exp=%h", bus.Program_Count, 32'hFFFF_FFFC); end
    cmp_cnt++; if (bus.Pc_Plus_4 !== 32'h0) begin fail_cnt++; $display("FAIL wrap_plus4 got=%h exp=0", bus.Pc_Plus_4); end
    cmp_cnt++; if (bus.Pc_Out_Of_Range !== 1'b1) begin fail_cnt++; $display("FAIL wrap_oor_hi got=%b exp=1", bus.Pc_Out_Of_Range); end
    step();
    cmp_cnt++; if (bus.Program_Count !== 32'h0) begin fail_cnt++; $display("FAIL wrap_pc got=%h exp=0", bus.Program_Count); end
    cmp_cnt++; if (bus.Pc_Out_Of_Range !== 1'b0) begin fail_cnt++; $display("FAIL wrap_oor_lo got=%b exp=0", bus.Pc_Out_Of_Range); end
    $display("wrap: pc=%h oor=%b", bus.Program_Count, bus.Pc_Out_Of_Range);
  endtask

  task automatic test_mid_reset();
    step();
    cmp_cnt++; if (bus.Program_Count !== 32'h4) begin fail_cnt++; $display("FAIL midrst_pre_pc got=%h exp=%h", bus.Program_Count, 32'h4); end
    rst = 1'b1; bus.Jump = 1'b1; bus.Jump_Target = 32'h80;
    step();
    rst = 1'b0; bus.Jump = 1'b0;
    cmp_cnt++; if (bus.Program_Count !== 32'h0) begin fail_cnt++; $display("FAIL midrst_pc got=%h exp=0", bus.Program_Count); end
    cmp_cnt++; if (bus.Fetch_Valid !== 1'b0) begin fail_cnt++; $display("FAIL midrst_fv got=%b exp=0", bus.Fetch_Valid); end
    cmp_cnt++; if (bus.Trap_Pc !== 32'h0) begin fail_cnt++; $display("FAIL midrst_trap_pc got=%h exp=0", bus.Trap_Pc); end
    $display("mid_reset: pc=%h fv=%b", bus.Program_Count, bus.Fetch_Valid);
    step();
    cmp_cnt++; if (bus.Program_Count !== 32'h4) begin fail_cnt++; $display("FAIL midrst_boot_pc got=%h exp=%h", bus.Program_Count, 32'h4); end
    cmp_cnt++; if (bus.Fetch_Valid !== 1'b1) begin fail_cnt++; $display("FAIL midrst_boot_fv got=%b exp=1", bus.Fetch_Valid); end
    $display("after_reset: pc=%h fv=%b", bus.Program_Count, bus.Fetch_Valid);
  endtask

  initial begin
    cmp_cnt  = 0;
    fail_cnt = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_jump_priority();
    test_stall();
    test_misalign();
    test_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end
endmodule
